// File: rtl/float_pkg.sv
// Shared binary32 field constants, FSM state type and field-extract helpers
// for the floating-point divider datapath.
package float_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  // Quotient bits: hidden, 23 fraction, guard, plus one for the <1.0 case.
  localparam int Q_W   = MAN_W + 3;
  localparam int CNT_W = $clog2(Q_W + 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, SPECIAL} state_t;

  function automatic logic f_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [MAN_W-1:0] f_frac(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/float_div_mant_div.sv
// mant_div: radix-2 restoring divider core for 24-bit significands, one
// quotient bit per clock, MSB first, Q_W bits per operation.
module mant_div
  import float_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [MAN_W:0]   dividend,
  input  logic [MAN_W:0]   divisor,
  output logic [Q_W-1:0]   q,
  output logic             rem_nz,
  output logic             step_done
);

  // Partial remainder stays below 2*divisor, so it needs one bit more.
  logic [MAN_W+1:0] rem;
  logic [MAN_W:0]   dvsr;
  logic [CNT_W-1:0] count;
  logic             ge;
  logic [MAN_W:0]   diff;
  logic [MAN_W:0]   r_next;

  always_comb begin
    ge     = rem >= {1'b0, dvsr};
    diff   = rem[MAN_W:0] - dvsr;
    r_next = ge ? diff : rem[MAN_W:0];
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain steps within one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      dvsr  <= '0;
      q     <= '0;
      count <= CNT_W'(Q_W);
    end else if (load) begin
      rem   <= {1'b0, dividend};
      dvsr  <= divisor;
      q     <= '0;
      count <= '0;
    end else if (count != CNT_W'(Q_W)) begin
      q     <= {q[Q_W-2:0], ge};
      rem   <= {r_next, 1'b0};
      count <= count + 1'b1;
    end
  end

  assign rem_nz = |rem;
  // High during the cycle whose closing edge performs the final step.
  assign step_done = (count == CNT_W'(Q_W - 1));

endmodule

// File: rtl/float_div.sv
// float_div: sequential binary32 divider with start/done handshake.
// Define FLOAT_DIV_RNE_EN for round-to-nearest-even; otherwise truncates.
module float_div
  import float_pkg::*;
#(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero
);

`ifdef FLOAT_DIV_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  state_t           state;
  logic             sign_r;
  logic [EXP_W-1:0] ea_r;
  logic [EXP_W-1:0] eb_r;

  logic             special_in;
  logic             load;
  logic [Q_W-1:0]   q;
  logic             rem_nz;
  logic             step_done;

  logic [31:0]       spec_res;
  logic              spec_dbz;
  logic signed [9:0] e_base;
  logic signed [9:0] e_adj;
  logic signed [9:0] e_rnd;
  logic [MAN_W-1:0]  frac;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [MAN_W:0]    frac_sum;
  logic [31:0]       norm_res;

  assign special_in = (f_exp(a) == EXP_MAX) || (f_exp(b) == EXP_MAX) ||
                      (f_exp(a) == '0)      || (f_exp(b) == '0);
  assign load = (state == IDLE) && start && !special_in;

  mant_div u_mant_div (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .dividend  ({1'b1, f_frac(a)}),
    .divisor   ({1'b1, f_frac(b)}),
    .q         (q),
    .rem_nz    (rem_nz),
    .step_done (step_done)
  );

  // NOTE: every output of a combinational block gets a default first so
  // no path leaves it unassigned and infers a latch.
  always_comb begin
    spec_res = {sign_r, 31'b0};
    spec_dbz = 1'b0;
    if (ea_r == EXP_MAX || eb_r == EXP_MAX) begin
      spec_res = QNAN;
    end else if (eb_r == '0) begin
      spec_res = {sign_r, POS_INF[30:0]};
      spec_dbz = 1'b1;
    end
  end

  // Quotient in [0.5, 2): q[Q_W-1] tells which binade it landed in.
  always_comb begin
    e_base = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + 10'(BIAS);
    if (q[Q_W-1]) begin
      e_adj  = e_base;
      frac   = q[Q_W-2:2];
      guard  = q[1];
      sticky = q[0] | rem_nz;
    end else begin
      e_adj  = e_base - 10'sd1;
      frac   = q[Q_W-3:1];
      guard  = q[0];
      sticky = rem_nz;
    end
    round_up = RNE & guard & (sticky | frac[0]);
    frac_sum = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
    e_rnd    = e_adj + 10'(frac_sum[MAN_W]);

    if (e_rnd >= $signed({2'b00, EXP_MAX})) begin
      norm_res = {sign_r, POS_INF[30:0]};
    end else if (e_rnd <= 10'sd0) begin
      norm_res = {sign_r, 31'b0};
    end else begin
      norm_res = {sign_r, e_rnd[EXP_W-1:0], frac_sum[MAN_W-1:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      sign_r      <= 1'b0;
      ea_r        <= '0;
      eb_r        <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sign_r <= f_sign(a) ^ f_sign(b);
            ea_r   <= f_exp(a);
            eb_r   <= f_exp(b);
            busy   <= 1'b1;
            state  <= special_in ? SPECIAL : DIVIDE;
          end
        end
        DIVIDE: begin
          if (step_done) state <= NORM;
        end
        NORM: begin
          result      <= norm_res;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        SPECIAL: begin
          result      <= spec_res;
          div_by_zero <= spec_dbz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_div.sv
// Self-checking bench for float_div: directed plan cases plus random operands
// against an integer-arithmetic reference model, checked by a scoreboard.
module tb_float_div;

`ifdef FLOAT_DIV_RNE_EN
  localparam bit RNE = 1'b1;
  localparam logic [31:0] THIRD = 32'h3EAA_AAAB;
`else
  localparam bit RNE = 1'b0;
  localparam logic [31:0] THIRD = 32'h3EAA_AAAA;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;

  float_div #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Reference: quotient of significands by integer division, then the
  // normalise / round / range rules applied directly.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic z, output int lat);
    logic s = x[31] ^ y[31];
    int ex = int'(x[30:23]);
    int ey = int'(y[30:23]);
    longint unsigned mx, my, num, quo, rem, mant, lowmask;
    int e, sh;
    bit g, st;
    z = 1'b0;
    lat = 1;
    if (ex == 255 || ey == 255) begin
      r = 32'h7FC0_0000;
    end else if (ey == 0) begin
      r = {s, 8'hFF, 23'h0};
      z = 1'b1;
    end else if (ex == 0) begin
      r = {s, 31'h0};
    end else begin
      lat = 27;
      mx = 64'(x[22:0]) + (64'd1 << 23);
      my = 64'(y[22:0]) + (64'd1 << 23);
      num = mx << 25;
      quo = num / my;
      rem = num % my;
      e = ex - ey + 127;
      if (quo >= (64'd1 << 25)) sh = 2;
      else begin
        sh = 1;
        e = e - 1;
      end
      mant = quo >> sh;
      g = quo[sh-1];
      lowmask = (64'd1 << (sh - 1)) - 64'd1;
      st = ((quo & lowmask) != 0) || (rem != 0);
      if (RNE && g && (st || mant[0])) mant = mant + 1;
      if (mant >= (64'd1 << 24)) begin
        mant = mant >> 1;
        e = e + 1;
      end
      if (e >= 255) r = {s, 8'hFF, 23'h0};
      else if (e <= 0) r = {s, 31'h0};
      else r = {s, 8'(e), mant[22:0]};
    end
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] x = $urandom;
    int k = $urandom_range(0, 15);
    if (k == 0) x[30:23] = 8'h00;
    else if (k == 1) x[30:23] = 8'hFF;
    else if (k < 6) x[30:23] = 8'($urandom_range(1, 254));
    else x[30:23] = 8'($urandom_range(100, 154));
    return x;
  endfunction

  // Scoreboard monitor: every done pops one expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: result %h with no operation pending", result);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("result %h/%h", mon_e.a, mon_e.b), result, mon_e.res);
        check($sformatf("div_by_zero %h/%h", mon_e.a, mon_e.b), 32'(div_by_zero), 32'(mon_e.z));
        check($sformatf("latency %h/%h", mon_e.a, mon_e.b), 32'(cyc - mon_e.acc), 32'(mon_e.lat));
        check("busy_low_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Called at a negedge where the DUT can accept; the next posedge is E0.
  task automatic launch(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] want, input logic z, input int lat);
    exp_t e;
    a = x;
    b = y;
    start = 1'b1;
    e.a = x;
    e.b = y;
    e.res = want;
    e.z = z;
    e.lat = lat;
    e.acc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 100);
    if (done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", n);
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] want, input logic z, input int lat);
    launch(x, y, want, z, lat);
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  task automatic run_rand(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    logic z;
    int lat;
    ref_div(x, y, r, z, lat);
    run_op(x, y, r, z, lat);
  endtask

  initial begin
    int busy_cnt;
    int n;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_div_by_zero", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 6/2: latency and busy coverage of the whole operation.
    launch(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 27);
    busy_cnt = 0;
    n = 0;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      n++;
    end
    check("busy_cycles_6_div_2", 32'(busy_cnt), 32'd27);

    // 1/3 twice with start held high across done.
    launch(32'h3F80_0000, 32'h4040_0000, THIRD, 1'b0, 27);
    wait_done();
    launch(32'h3F80_0000, 32'h4040_0000, THIRD, 1'b0, 27);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Special operands.
    run_op(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1);
    run_op(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1);

    // Range limits.
    run_op(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b0, 27);
    run_op(32'h0080_0000, 32'h4B00_0000, 32'h0000_0000, 1'b0, 27);
    run_op(32'hC000_0000, 32'h3F00_0000, 32'hC080_0000, 1'b0, 27);

    // start pulses mid-operation are ignored.
    launch(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 27);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = 32'h3F80_0000;
    b = 32'h0000_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    a = 32'h7FC0_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (35) @(negedge clk);

    // Leave a non-zero result and div_by_zero behind, then reset mid-divide.
    run_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1);
    launch(32'h3F80_0000, 32'h4040_0000, THIRD, 1'b0, 27);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_result", result, 32'd0);
    check("async_rst_div_by_zero", 32'(div_by_zero), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (35) @(negedge clk);
    run_op(32'h4120_0000, 32'h40A0_0000, 32'h4000_0000, 1'b0, 27);

    // Random operands against the reference model.
    for (int i = 0; i < 60; i++) begin
      run_rand(rand_operand(), rand_operand());
    end

    repeat (40) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
